// File: rtl/gpc_pkg.sv
// Shared definitions for the 1406:5 GPC checker.
// Field widths of the counter's operands and result, plus the checker FSM states.
package gpc_pkg;

    localparam int GPC1406_SRC0_W = 6;
    localparam int GPC1406_SRC2_W = 4;
    localparam int GPC1406_SRC3_W = 1;
    localparam int GPC1406_DST_W  = 5;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } chk_state_t;

endpackage

// File: rtl/gpc_popcount.sv
// Combinational population count of a W-bit vector.
// Ports: i_bits (W) in, o_count ($clog2(W+1)) out = number of set bits.
module gpc_popcount #(
    parameter int W = 6
) (
    input  logic [W-1:0]             i_bits,
    output logic [$clog2(W+1)-1:0]   o_count
);

    localparam int CW = $clog2(W+1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < W; i++) begin
            o_count = o_count + CW'(i_bits[i]);
        end
    end

endmodule

// File: rtl/gpc1406_5_checker.sv
// Response checker for a 1406:5 generalized parallel counter.
// Ports: clk/rst (sync, active-high), start, in_valid/in_ready handshake,
//   src0/src2/src3/dst vector+response in; busy/done/pass status,
//   check_count/err_count statistics, first_err_* capture of first mismatch.
module gpc1406_5_checker
    import gpc_pkg::*;
#(
    parameter int N_CHECKS = 20,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [GPC1406_SRC0_W-1:0] src0,
    input  logic [GPC1406_SRC2_W-1:0] src2,
    input  logic [GPC1406_SRC3_W-1:0] src3,
    input  logic [GPC1406_DST_W-1:0]  dst,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [CNT_W-1:0]          check_count,
    output logic [CNT_W-1:0]          err_count,
    output logic                      first_err_valid,
    output logic [GPC1406_SRC0_W-1:0] first_err_src0,
    output logic [GPC1406_SRC2_W-1:0] first_err_src2,
    output logic [GPC1406_SRC3_W-1:0] first_err_src3,
    output logic [GPC1406_DST_W-1:0]  first_err_dst,
    output logic [GPC1406_DST_W-1:0]  first_err_exp
);

    localparam int ACC_W = $clog2(N_CHECKS + 1);
    localparam int PC0_W = $clog2(GPC1406_SRC0_W + 1);
    localparam int PC2_W = $clog2(GPC1406_SRC2_W + 1);
    localparam int DW    = GPC1406_DST_W;

    chk_state_t r_state;
    chk_state_t w_state_nxt;

    logic [ACC_W-1:0] r_acc_cnt;
    logic             w_acc;
    logic             w_last;
    logic             w_enter_run;

    logic [PC0_W-1:0] w_pc0;
    logic [PC2_W-1:0] w_pc2;
    logic [DW-1:0]    w_exp;

    // Stage 1: popcounts plus raw snapshot
    logic                      r_s1_vld;
    logic [PC0_W-1:0]          r_s1_pc0;
    logic [PC2_W-1:0]          r_s1_pc2;
    logic [GPC1406_SRC0_W-1:0] r_s1_src0;
    logic [GPC1406_SRC2_W-1:0] r_s1_src2;
    logic [GPC1406_SRC3_W-1:0] r_s1_src3;
    logic [DW-1:0]             r_s1_dst;

    // Stage 2: weighted sum plus snapshot, retired into the counters
    logic                      r_s2_vld;
    logic [DW-1:0]             r_s2_exp;
    logic [GPC1406_SRC0_W-1:0] r_s2_src0;
    logic [GPC1406_SRC2_W-1:0] r_s2_src2;
    logic [GPC1406_SRC3_W-1:0] r_s2_src3;
    logic [DW-1:0]             r_s2_dst;

    logic [CNT_W-1:0]          r_check_cnt;
    logic [CNT_W-1:0]          r_err_cnt;
    logic                      r_fe_vld;
    logic [GPC1406_SRC0_W-1:0] r_fe_src0;
    logic [GPC1406_SRC2_W-1:0] r_fe_src2;
    logic [GPC1406_SRC3_W-1:0] r_fe_src3;
    logic [DW-1:0]             r_fe_dst;
    logic [DW-1:0]             r_fe_exp;

    gpc_popcount #(.W(GPC1406_SRC0_W)) u_pc0 (
        .i_bits  (src0),
        .o_count (w_pc0)
    );

    gpc_popcount #(.W(GPC1406_SRC2_W)) u_pc2 (
        .i_bits  (src2),
        .o_count (w_pc2)
    );

    assign in_ready    = (r_state == RUN);
    assign w_acc       = in_valid && in_ready;
    assign w_last      = (r_acc_cnt == ACC_W'(N_CHECKS - 1));
    assign w_enter_run = start && ((r_state == IDLE) || (r_state == DONE));

    assign w_exp = DW'(r_s1_pc0)
                 + (DW'(r_s1_pc2) << 2)
                 + (DW'(r_s1_src3) << 3);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (start) w_state_nxt = RUN;
            RUN:   if (w_acc && w_last) w_state_nxt = DRAIN;
            // Stage 2 retires on the same edge that enters DONE,
            // so the statistics are final when done is seen.
            DRAIN: if (!r_s1_vld) w_state_nxt = DONE;
            DONE:  if (start) w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            r_acc_cnt <= '0;
        end else if (w_acc) begin
            r_acc_cnt <= r_acc_cnt + ACC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld <= 1'b0;
            r_s2_vld <= 1'b0;
        end else begin
            r_s1_vld <= w_acc;
            r_s2_vld <= r_s1_vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_pc0  <= '0;
            r_s1_pc2  <= '0;
            r_s1_src0 <= '0;
            r_s1_src2 <= '0;
            r_s1_src3 <= '0;
            r_s1_dst  <= '0;
            r_s2_exp  <= '0;
            r_s2_src0 <= '0;
            r_s2_src2 <= '0;
            r_s2_src3 <= '0;
            r_s2_dst  <= '0;
        end else begin
            r_s1_pc0  <= w_pc0;
            r_s1_pc2  <= w_pc2;
            r_s1_src0 <= src0;
            r_s1_src2 <= src2;
            r_s1_src3 <= src3;
            r_s1_dst  <= dst;
            r_s2_exp  <= w_exp;
            r_s2_src0 <= r_s1_src0;
            r_s2_src2 <= r_s1_src2;
            r_s2_src3 <= r_s1_src3;
            r_s2_dst  <= r_s1_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_enter_run) begin
            r_check_cnt <= '0;
            r_err_cnt   <= '0;
            r_fe_vld    <= 1'b0;
            r_fe_src0   <= '0;
            r_fe_src2   <= '0;
            r_fe_src3   <= '0;
            r_fe_dst    <= '0;
            r_fe_exp    <= '0;
        end else if (r_s2_vld) begin
            if (r_check_cnt != '1) begin
                r_check_cnt <= r_check_cnt + CNT_W'(1);
            end
            if (r_s2_exp != r_s2_dst) begin
                if (r_err_cnt != '1) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
                if (!r_fe_vld) begin
                    r_fe_vld  <= 1'b1;
                    r_fe_src0 <= r_s2_src0;
                    r_fe_src2 <= r_s2_src2;
                    r_fe_src3 <= r_s2_src3;
                    r_fe_dst  <= r_s2_dst;
                    r_fe_exp  <= r_s2_exp;
                end
            end
        end
    end

    assign busy            = (r_state == RUN) || (r_state == DRAIN);
    assign done            = (r_state == DONE);
    assign pass            = done && (r_err_cnt == '0);
    assign check_count     = r_check_cnt;
    assign err_count       = r_err_cnt;
    assign first_err_valid = r_fe_vld;
    assign first_err_src0  = r_fe_src0;
    assign first_err_src2  = r_fe_src2;
    assign first_err_src3  = r_fe_src3;
    assign first_err_dst   = r_fe_dst;
    assign first_err_exp   = r_fe_exp;

endmodule

// File: doc/gpc1406_5_checker.md
# gpc1406_5_checker

Synthesizable response checker for the 1406:5 generalized parallel counter. It sits on the output side of a `gpc1406_5` instance under test and accepts each applied input vector together with the counter's `dst`. For every vector it recomputes the weighted bit sum through a 2-stage pipeline, compares it, and accumulates pass/fail statistics over a run of `N_CHECKS` vectors. It complements the stimulus driver: the driver produces vectors, this block judges the responses in hardware.

## Interface
- `N_CHECKS`, default 20: vectors accepted per run, at least 1.
- `CNT_W`, default 16: width of the check and error counters.
- `clk`  in  1  the single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a run; honoured in IDLE and DONE only.
- `in_valid`  in  1  a vector and its response are presented.
- `in_ready`  out  1  the block accepts a vector this cycle.
- `src0`  in  6  weight-1 bits.
- `src2`  in  4  weight-4 bits.
- `src3`  in  1  weight-8 bit.
- `dst`  in  5  the counter's result for this vector.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  high while in DONE.
- `pass`  out  1  high in DONE when `err_count` is 0; otherwise 0.
- `check_count`  out  CNT_W  number of vectors compared.
- `err_count`  out  CNT_W  number of mismatches.
- `first_err_valid`  out  1  a mismatch has been captured this run.
- `first_err_src0`, `first_err_src2`, `first_err_src3`, `first_err_dst`, `first_err_exp`  out  6/4/1/5/5  inputs, `dst` and expected value of the first failing vector.

## Operation
- States:
  - IDLE → RUN on `start`.
  - RUN → DRAIN on the edge that accepts vector number `N_CHECKS`.
  - DRAIN → DONE when both pipeline stages are empty.
  - DONE → RUN on `start`.
- `start` in RUN or DRAIN is ignored.
- Entering RUN clears `check_count`, `err_count`, `first_err_valid` and all `first_err_*` fields.
- `in_ready` = 1 only in RUN. A vector is accepted on an edge where `in_valid && in_ready`. The source may hold `in_valid` high; there is no backpressure apart from `in_ready`.
- Stage 1 registers:
  - popcount of `src0` (3 bits, 0–6);
  - popcount of `src2` (3 bits, 0–4);
  - `src3`, `dst` and the raw inputs for capture;
  - a valid bit.
- Stage 2 computes `exp = pc0 + (pc2<<2) + (src3<<3)`, 5 bits, range 0–30, no overflow possible.
  - `check_count` increments on every compare.
  - On `exp != dst`, `err_count` increments.
  - If `first_err_valid` is 0, the stage-1 snapshot is captured and `first_err_valid` is set.
- Counters saturate at all-ones and do not wrap.
- Accepted-vector counter: internal, `$clog2(N_CHECKS+1)` bits, cleared on entry to RUN.

## Timing
- Reset values:
  - state = IDLE;
  - `in_ready`, `busy`, `done`, `pass`, `first_err_valid` = 0;
  - all counters and `first_err_*` fields = 0;
  - pipeline valids = 0.
- Latency: a vector accepted at edge k updates the counters at edge k+2, visible in the cycle after.
- Throughput: one vector per cycle in RUN.
- Back-to-back mismatches: only the earliest one is captured.
- DRAIN lasts at most 2 cycles. `done` rises at most 3 edges after the last accept.
- `N_CHECKS` = 1: exactly one accept, then DRAIN.
- `start` in DONE:
  - counters clear on the same edge that enters RUN;
  - `done` falls and `in_ready` rises in the next cycle.
- `rst` mid-run: return to IDLE on that edge. In-flight pipeline contents are discarded and not counted.

## Structure
- Shared package `gpc_pkg` holds:
  - `GPC1406_SRC0_W=6`, `GPC1406_SRC2_W=4`, `GPC1406_SRC3_W=1`, `GPC1406_DST_W=5`;
  - the state enum `chk_state_t` {IDLE, RUN, DRAIN, DONE}.
- Sub-module `gpc_popcount` (parameter `W`, combinational) is instantiated twice in stage 1.
- Everything else, including the pipeline, FSM, counters and capture, lives in the top.

## Test plan
- Reset, then `start`; feed 20 correct vectors back-to-back. First vector: `src0=6'h2d`, `src2=4'ha`, `src3=0`, `dst=5'h0c`. Required: `check_count`=20, `err_count`=0, `pass`=1, `done` high ≤3 cycles after the last accept.
- Boundary values:
  - `src0=6'h3f`, `src2=4'hf`, `src3=1`, `dst=5'h1e` → match;
  - all-zero inputs with `dst=0` → match.
- Error injection: `src0=6'h20`, `src2=4'h5`, `src3=1`, `dst=5'h10` (expected 5'h11) → `err_count`=1, `first_err_exp`=5'h11, `first_err_dst`=5'h10, `pass`=0. A second mismatch later in the run does not overwrite the captured fields.
- `in_valid` toggled every other cycle plus `start` pulses during RUN → exactly 20 accepts, and the `start` pulses have no effect.
- Assert `rst` 1 cycle after an accept → IDLE; counters read 0; the in-flight vector is never counted.
- `start` in DONE → counters clear, a second run of 20 completes with independent results.
